// File: rtl/alu_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv
// Brief    : Iterative radix-2 MULT/DIV unit with HI/LO registers and a
//            start/busy/done handshake; divider present only with MULDIV_DIV_EN.
// Revision : 1.0 - initial release
// ============================================================================
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             usigned,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int         c_CNT_W   = $clog2(WIDTH) + 1;

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_CALC    = 2'd1;
    localparam logic [1:0] c_FIX     = 2'd2;

    localparam logic [1:0] c_OP_MULT = 2'b00;
    localparam logic [1:0] c_OP_DIV  = 2'b01;
    localparam logic [1:0] c_OP_MTHI = 2'b10;
    localparam logic [1:0] c_OP_MTLO = 2'b11;

    localparam logic [1:0] c_K_MUL   = 2'd0;
    localparam logic [1:0] c_K_NOP   = 2'd3;
`ifdef MULDIV_DIV_EN
    localparam logic [1:0] c_K_DIV   = 2'd1;
    localparam logic [1:0] c_K_DZ    = 2'd2;
`endif

    logic [1:0]         r_state;
    logic [1:0]         r_kind;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic               r_psign;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_div_zero;

    logic [WIDTH-1:0]   w_ma;
    logic [WIDTH-1:0]   w_mb;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [2*WIDTH-1:0] w_prod_fix;

    always_comb begin
        w_ma       = (usigned && a[WIDTH-1]) ? -a : a;
        w_mb       = (usigned && b[WIDTH-1]) ? -b : b;
        // Accumulator = {partial product, remaining multiplier bits}
        w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                   + (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
        w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
        w_prod_fix = r_psign ? -r_acc : r_acc;
    end

`ifdef MULDIV_DIV_EN
    logic               r_rsign;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic [2*WIDTH-1:0] w_div_next;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    // Accumulator = {partial remainder, dividend bits / quotient bits}
    always_comb begin
        w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
        w_div_diff  = w_div_shift - {1'b0, r_opnd};
        w_div_next  = w_div_diff[WIDTH]
                    ? {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                    : {w_div_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};
        w_quot_fix  = r_psign ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_rem_fix   = r_rsign ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_kind     <= c_K_MUL;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_opnd     <= '0;
            r_psign    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_div_zero <= 1'b0;
`ifdef MULDIV_DIV_EN
            r_rsign    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_div_zero <= 1'b0;
                        case (op)
                            c_OP_MULT: begin
                                r_kind  <= c_K_MUL;
                                r_acc   <= {{WIDTH{1'b0}}, w_mb};
                                r_opnd  <= w_ma;
                                r_psign <= usigned & (a[WIDTH-1] ^ b[WIDTH-1]);
                                r_cnt   <= c_CNT_W'(WIDTH);
                                r_busy  <= 1'b1;
                                r_state <= c_CALC;
                            end
                            c_OP_DIV: begin
`ifdef MULDIV_DIV_EN
                                if (b == '0) begin
                                    r_kind  <= c_K_DZ;
                                    r_acc   <= {a, {WIDTH{1'b1}}};
                                    r_busy  <= 1'b1;
                                    r_state <= c_FIX;
                                end else begin
                                    r_kind  <= c_K_DIV;
                                    r_acc   <= {{WIDTH{1'b0}}, w_ma};
                                    r_opnd  <= w_mb;
                                    r_psign <= usigned & (a[WIDTH-1] ^ b[WIDTH-1]);
                                    r_rsign <= usigned & a[WIDTH-1];
                                    r_cnt   <= c_CNT_W'(WIDTH);
                                    r_busy  <= 1'b1;
                                    r_state <= c_CALC;
                                end
`else
                                r_kind  <= c_K_NOP;
                                r_busy  <= 1'b1;
                                r_state <= c_FIX;
`endif
                            end
                            c_OP_MTHI: begin
                                r_hi   <= a;
                                r_done <= 1'b1;
                            end
                            c_OP_MTLO: begin
                                r_lo   <= a;
                                r_done <= 1'b1;
                            end
                        endcase
                    end
                end
                c_CALC: begin
`ifdef MULDIV_DIV_EN
                    r_acc <= (r_kind == c_K_DIV) ? w_div_next : w_mul_next;
`else
                    r_acc <= w_mul_next;
`endif
                    r_cnt <= r_cnt - c_CNT_W'(1);
                    if (r_cnt == c_CNT_W'(1)) begin
                        r_state <= c_FIX;
                    end
                end
                c_FIX: begin
                    case (r_kind)
                        c_K_MUL: {r_hi, r_lo} <= w_prod_fix;
`ifdef MULDIV_DIV_EN
                        c_K_DIV: begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quot_fix;
                        end
                        c_K_DZ: begin
                            {r_hi, r_lo} <= r_acc;
                            r_div_zero   <= 1'b1;
                        end
`endif
                        default: ;
                    endcase
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign div_zero = r_div_zero;

endmodule
`default_nettype wire
